// File: rtl/display_colour_adapt.sv
// Colour-depth adapter between the display core and the TMDS/DVI generator.
// The pipeline has two stages. Stage 1 holds the input pixel, the syncs and the
// dither offset. Stage 2 holds the converted colour and the delayed syncs.
// Position and frame counters advance on the raw inputs. The offset for a
// pixel therefore comes from the counter values it arrives with.

// Converts one colour channel. The mode is resolved at elaboration time.
module display_colour_adapt_lane #(
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8,
  parameter int MODE_EFF = 0
) (
  input  logic [BPC_IN-1:0]  c,
  input  logic [12:0]        ofs,
  output logic [BPC_OUT-1:0] q
);
  // Several modes ignore the offset or the low input bits.
  logic lane_unused;
  assign lane_unused = ^{c, ofs};

  generate
    if (MODE_EFF == 1) begin : g_pad
      assign q = {c, {(BPC_OUT-BPC_IN){1'b0}}};
    end else if (MODE_EFF == 2) begin : g_trn
      assign q = c[BPC_IN-1 -: BPC_OUT];
    end else if (MODE_EFF == 3) begin : g_dth
      localparam int D = BPC_IN - BPC_OUT;
      logic [BPC_IN:0]   sum;
      logic [BPC_IN-1:0] sat;
      // The offset is always below 2^D, so ofs[BPC_IN:0] keeps every bit of it.
      assign sum = {1'b0, c} + ofs[BPC_IN:0];
      assign sat = sum[BPC_IN] ? {BPC_IN{1'b1}} : sum[BPC_IN-1:0];
      assign q   = sat[BPC_IN-1:D];
    end else begin : g_rep
      // The input is repeated MSB-first. With equal widths this is a plain copy.
      for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
        assign q[BPC_OUT-1-i] = c[BPC_IN-1-(i % BPC_IN)];
      end
    end
  endgenerate
endmodule

module display_colour_adapt #(
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8,
  parameter int CHANNELS = 3,
  parameter int MODE     = 0,
  parameter int TEMPORAL = 1,
  parameter int VS_POL   = 1
) (
  input  logic                         clk_pix,
  input  logic                         rst_pix_n,
  input  logic                         in_hsync,
  input  logic                         in_vsync,
  input  logic                         in_de,
  input  logic [CHANNELS*BPC_IN-1:0]   in_colr,
  output logic                         out_hsync,
  output logic                         out_vsync,
  output logic                         out_de,
  output logic [CHANNELS*BPC_OUT-1:0]  out_colr
);
  localparam int D = BPC_IN - BPC_OUT;
  // A mode that does not fit the width pairing falls back to replicate or truncate.
  localparam int MODE_EFF = (BPC_OUT == BPC_IN) ? 0 :
                            (BPC_OUT >  BPC_IN) ? ((MODE == 1) ? 1 : 0) :
                                                  ((MODE == 3) ? 3 : 2);
  localparam int SHR = (D > 0 && D <= 4) ? 4 - D : 0;
  localparam int SHL = (D > 4) ? D - 4 : 0;
  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  logic [1:0] x, y, frame;
  logic       de_q, vs_q;
  logic       vs_edge;
  logic [1:0] xi, yi;
  logic [3:0] t;
  logic [12:0] ofs;

  logic                              s1_hs, s1_vs, s1_de;
  logic [CHANNELS-1:0][BPC_IN-1:0]   s1_colr;
  logic [12:0]                       s1_ofs;
  logic [CHANNELS-1:0][BPC_OUT-1:0]  conv;

  assign vs_edge = (in_vsync == VS_ACT) && (vs_q != VS_ACT);

  // Position and frame counters. A vsync edge takes priority over a falling edge of de.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      x     <= '0;
      y     <= '0;
      frame <= '0;
      de_q  <= 1'b0;
      vs_q  <= ~VS_ACT;
    end else begin
      de_q <= in_de;
      vs_q <= in_vsync;
      if (vs_edge) begin
        x <= '0;
        y <= '0;
        if (TEMPORAL != 0) frame <= frame + 2'd1;
      end else begin
        x <= in_de ? x + 2'd1 : 2'd0;
        if (de_q && !in_de) y <= y + 2'd1;
      end
    end
  end

  // Every channel of a pixel uses one offset, scaled to the number of dropped bits.
  assign xi  = x + frame;
  assign yi  = y + frame;
  assign t   = BAYER[{yi, xi}];
  assign ofs = (D > 0) ? (({9'd0, t} >> SHR) << SHL) : 13'd0;

  // Stage 1: register the input pixel, the syncs and the dither offset.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_hs   <= 1'b0;
      s1_vs   <= ~VS_ACT;
      s1_de   <= 1'b0;
      s1_colr <= '0;
      s1_ofs  <= '0;
    end else begin
      s1_hs   <= in_hsync;
      s1_vs   <= in_vsync;
      s1_de   <= in_de;
      s1_colr <= in_colr;
      s1_ofs  <= ofs;
    end
  end

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
      display_colour_adapt_lane #(
        .BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE_EFF(MODE_EFF)
      ) u_lane (
        .c(s1_colr[ch]),
        .ofs(s1_ofs),
        .q(conv[ch])
      );
    end
  endgenerate

  // Stage 2: register the converted colour, forced to zero during blanking.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      out_hsync <= 1'b0;
      out_vsync <= ~VS_ACT;
      out_de    <= 1'b0;
      out_colr  <= '0;
    end else begin
      out_hsync <= s1_hs;
      out_vsync <= s1_vs;
      out_de    <= s1_de;
      out_colr  <= s1_de ? conv : '0;
    end
  end
endmodule

// File: tb/tb_display_colour_adapt.sv
// Directed bench. Five adapter instances share one pixel stream: replicate and
// zero-pad 5->8, and truncate and two dither variants 8->5.
module tb_display_colour_adapt;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, de;
  logic [14:0] c5;
  logic [23:0] c8;

  logic        rep_hs, rep_vs, rep_de, pad_hs, pad_vs, pad_de;
  logic        trn_hs, trn_vs, trn_de, dth_hs, dth_vs, dth_de, dtt_hs, dtt_vs, dtt_de;
  logic [23:0] rep_c, pad_c;
  logic [14:0] trn_c, dth_c, dtt_c;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  display_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .MODE(0), .TEMPORAL(1), .VS_POL(1)) u_rep (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c5),
    .out_hsync(rep_hs), .out_vsync(rep_vs), .out_de(rep_de), .out_colr(rep_c));
  display_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .MODE(1), .TEMPORAL(1), .VS_POL(1)) u_pad (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c5),
    .out_hsync(pad_hs), .out_vsync(pad_vs), .out_de(pad_de), .out_colr(pad_c));
  display_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .MODE(2), .TEMPORAL(1), .VS_POL(1)) u_trn (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c8),
    .out_hsync(trn_hs), .out_vsync(trn_vs), .out_de(trn_de), .out_colr(trn_c));
  display_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .MODE(3), .TEMPORAL(0), .VS_POL(1)) u_dth (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c8),
    .out_hsync(dth_hs), .out_vsync(dth_vs), .out_de(dth_de), .out_colr(dth_c));
  display_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .MODE(3), .TEMPORAL(1), .VS_POL(1)) u_dtt (
    .clk_pix(clk), .rst_pix_n(rst_n), .in_hsync(hs), .in_vsync(vs), .in_de(de), .in_colr(c8),
    .out_hsync(dtt_hs), .out_vsync(dtt_vs), .out_de(dtt_de), .out_colr(dtt_c));

  typedef struct {
    logic        h, v, d;
    logic [14:0] a5;
    logic [23:0] a8;
    logic [23:0] e_rep, e_pad;
    logic [14:0] e_trn, e_dth, e_dtt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic h, input logic v, input logic d,
                     input logic [14:0] a5, input logic [23:0] a8,
                     input logic [23:0] er, input logic [23:0] ep,
                     input logic [14:0] et, input logic [14:0] ed, input logic [14:0] eu);
    vec_t r;
    r.h = h; r.v = v; r.d = d; r.a5 = a5; r.a8 = a8;
    r.e_rep = er; r.e_pad = ep; r.e_trn = et; r.e_dth = ed; r.e_dtt = eu;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic d,
                       input logic [14:0] a5, input logic [23:0] a8);
    hs = h; vs = v; de = d; c5 = a5; c8 = a8;
  endtask

  logic [23:0] z24;
  logic [14:0] z15;
  logic [14:0] one3;

  initial begin
    z24 = '0; z15 = '0;
    one3 = {5'h01, 5'h01, 5'h01};

    // Cycle-by-cycle stream. Each comment gives the counter state (x,y,frame) of the pixel.
    add(0,0,0, {5'h1F,5'h1F,5'h1F}, 24'hFFFFFF, z24, z24, z15, z15, z15);       // blank
    add(1,0,1, {5'h1F,5'h10,5'h01}, {8'h04,8'h04,8'h04},
        {8'hFF,8'h84,8'h08}, {8'hF8,8'h80,8'h08}, z15, z15, z15);               // x0 y0 ofs0
    add(0,0,1, {5'h11,5'h11,5'h11}, {8'h04,8'h04,8'h04},
        {8'h8C,8'h8C,8'h8C}, {8'h88,8'h88,8'h88}, z15, one3, one3);             // x1 ofs4
    add(0,0,1, z15, {8'hC7,8'hC7,8'hC7}, z24, z24,
        {5'h18,5'h18,5'h18}, {5'h19,5'h19,5'h19}, {5'h19,5'h19,5'h19});         // x2 ofs1
    add(1,0,1, {5'h1F,5'h1F,5'h1F}, {8'h04,8'h04,8'h04},
        24'hFFFFFF, {8'hF8,8'hF8,8'hF8}, z15, one3, one3);                      // x3 ofs5
    add(1,0,0, {5'h15,5'h0A,5'h1F}, {8'hAA,8'h55,8'hFF}, z24, z24, z15, z15, z15); // blank, y->1
    add(0,0,1, {5'h00,5'h1F,5'h10}, 24'hFFFFFF, {8'h00,8'hFF,8'h84}, {8'h00,8'hF8,8'h80},
        15'h7FFF, 15'h7FFF, 15'h7FFF);                                           // y1 x0 saturate
    add(0,0,1, one3, z24, {8'h08,8'h08,8'h08}, {8'h08,8'h08,8'h08}, z15, z15, z15); // zero in
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);                              // y->2
    add(1,0,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, one3, one3);            // y2 x0 ofs1
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);                              // y->3
    add(0,0,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, one3, one3);            // y3 x0 ofs7
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);                              // y wraps 0
    add(0,0,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, z15, z15);              // y0 ofs0
    add(0,1,0, z15, z24, z24, z24, z15, z15, z15);                              // vs edge + de fall
    add(0,1,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, z15, one3);             // frame1: ofs 0 / 2
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);
    add(0,1,0, z15, z24, z24, z24, z15, z15, z15);                              // frame2
    add(0,1,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, z15, z15);              // ofs 0 / 0
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);
    add(0,1,0, z15, z24, z24, z24, z15, z15, z15);                              // frame3
    add(0,1,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, z15, one3);             // ofs 0 / 2
    add(0,0,0, z15, z24, z24, z24, z15, z15, z15);
    add(0,1,0, z15, z24, z24, z24, z15, z15, z15);                              // frame wraps 0
    add(0,1,1, z15, {8'h07,8'h07,8'h07}, z24, z24, z15, z15, z15);
    add(0,1,1, z15, {8'h03,8'h03,8'h03}, z24, z24, z15, z15, z15);              // x1 ofs4: 7>>3

    // Reset held with active inputs
    rst_n = 1'b0;
    drive(1, 1, 1, 15'h7FFF, 24'hFFFFFF);
    repeat (3) @(negedge clk);
    chk("reset out_de", {23'd0, rep_de}, 24'd0);
    chk("reset out_vsync", {23'd0, rep_vs}, 24'd0);
    chk("reset out_hsync", {23'd0, rep_hs}, 24'd0);
    chk("reset rep colr", rep_c, z24);
    chk("reset dth colr", {9'd0, dth_c}, z24);
    drive(0, 0, 0, z15, z24);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: a vector goes in at one negedge and is checked two negedges later
    for (int k = 0; k < tbl.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("v%0d hsync", k-2), {23'd0, rep_hs}, {23'd0, tbl[k-2].h});
        chk($sformatf("v%0d vsync", k-2), {23'd0, rep_vs}, {23'd0, tbl[k-2].v});
        chk($sformatf("v%0d de", k-2), {23'd0, rep_de}, {23'd0, tbl[k-2].d});
        chk($sformatf("v%0d rep", k-2), rep_c, tbl[k-2].e_rep);
        chk($sformatf("v%0d pad", k-2), pad_c, tbl[k-2].e_pad);
        chk($sformatf("v%0d trn", k-2), {9'd0, trn_c}, {9'd0, tbl[k-2].e_trn});
        chk($sformatf("v%0d dth", k-2), {9'd0, dth_c}, {9'd0, tbl[k-2].e_dth});
        chk($sformatf("v%0d dtt", k-2), {9'd0, dtt_c}, {9'd0, tbl[k-2].e_dtt});
      end
      if (k < tbl.size())
        drive(tbl[k].h, tbl[k].v, tbl[k].d, tbl[k].a5, tbl[k].a8);
      else
        drive(0, 0, 0, z15, z24);
    end

    // Asynchronous reset in the middle of a line
    drive(1, 0, 1, 15'h7FFF, {8'h04,8'h04,8'h04});
    repeat (3) @(negedge clk);
    chk("midline de before reset", {23'd0, rep_de}, 24'd1);
    chk("midline rep before reset", rep_c, 24'hFFFFFF);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset de", {23'd0, rep_de}, 24'd0);
    chk("async reset hsync", {23'd0, rep_hs}, 24'd0);
    chk("async reset rep colr", rep_c, z24);
    chk("async reset dth colr", {9'd0, dth_c}, z24);

    // After release, x counts from 0 again
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, z15, {8'h04,8'h04,8'h04});
    @(negedge clk);
    @(negedge clk);
    chk("post-reset x0 dth", {9'd0, dth_c}, z24);
    chk("post-reset x0 de", {23'd0, dth_de}, 24'd1);
    drive(0, 0, 0, z15, z24);
    @(negedge clk);
    chk("post-reset x1 dth", {9'd0, dth_c}, {9'd0, one3});
    chk("post-reset x1 dtt", {9'd0, dtt_c}, {9'd0, one3});
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
